// File: rtl/riscv_pkg.sv
// Shared types and constants for the RV32I pipeline front end.
package riscv_pkg;

   localparam int          XLEN_DEF     = 32;
   localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;
   localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

   typedef enum logic [1:0] {
      REQ  = 2'd0,
      BUF  = 2'd1,
      DROP = 2'd2
   } fetch_state_t;

   // Counter increment that sticks at all-ones instead of wrapping.
   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: reset > flush > stall > load.
module if_id_reg
   import riscv_pkg::*;
#(
   parameter int XLEN = XLEN_DEF
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            flushD,
   input  logic            stallD,
   input  logic            load,
   input  logic [31:0]     load_instr,
   input  logic [XLEN-1:0] load_pc,
   input  logic            load_valid,
   output logic [31:0]     instrD,
   output logic [XLEN-1:0] pcD,
   output logic [XLEN-1:0] pc_plus4D,
   output logic            validD
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         instrD    <= NOP_INSTR;
         pcD       <= '0;
         pc_plus4D <= '0;
         validD    <= 1'b0;
      end else if (flushD) begin
         instrD    <= NOP_INSTR;
         pcD       <= '0;
         pc_plus4D <= '0;
         validD    <= 1'b0;
      end else if (!stallD && load) begin
         instrD    <= load_instr;
         pcD       <= load_pc;
         pc_plus4D <= load_pc + XLEN'(4);
         validD    <= load_valid;
      end
   end

endmodule

// File: rtl/fetch_stage.sv
// IF stage: PC register, single-outstanding imem request FSM and IF/ID register.
// Optional FETCH_PERF_CNT_EN adds saturating bubble_cnt / drop_cnt outputs.
module fetch_stage
   import riscv_pkg::*;
#(
   parameter int              XLEN     = XLEN_DEF,
   parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEF)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            stallF,
   input  logic            stallD,
   input  logic            flushD,
   input  logic            pc_src,
   input  logic [XLEN-1:0] pc_targetE,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_rvalid,
   input  logic [31:0]     imem_rdata,
   output logic [31:0]     instrD,
   output logic [XLEN-1:0] pcD,
   output logic [XLEN-1:0] pc_plus4D,
   output logic            validD
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0]     bubble_cnt,
   output logic [31:0]     drop_cnt
`endif
);

   fetch_state_t    state_reg, state_next;
   logic [XLEN-1:0] pcf_reg, pcf_next;
   logic [XLEN-1:0] held_addr_reg, held_addr_next;
   logic [31:0]     buf_instr_reg, buf_instr_next;

   logic            accept;
   logic [XLEN-1:0] target;
   logic [XLEN-1:0] pcf_plus4;

   logic            ifid_load;
   logic [31:0]     ifid_instr;
   logic [XLEN-1:0] ifid_pc;
   logic            ifid_valid;
   logic            bubble_ld;
   logic            bubble_evt;
   logic            drop_evt;

   assign accept    = !stallD;
   assign target    = pc_targetE & ~XLEN'(3);
   assign pcf_plus4 = pcf_reg + XLEN'(4);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg     <= REQ;
         pcf_reg       <= RESET_PC;
         held_addr_reg <= '0;
         buf_instr_reg <= NOP_INSTR;
      end else begin
         state_reg     <= state_next;
         pcf_reg       <= pcf_next;
         held_addr_reg <= held_addr_next;
         buf_instr_reg <= buf_instr_next;
      end
   end

   always_comb begin
      state_next     = state_reg;
      pcf_next       = pcf_reg;
      held_addr_next = held_addr_reg;
      buf_instr_next = buf_instr_reg;
      imem_req       = 1'b0;
      imem_addr      = pcf_reg;
      ifid_load      = 1'b0;
      ifid_instr     = NOP_INSTR;
      ifid_pc        = '0;
      ifid_valid     = 1'b0;
      bubble_ld      = 1'b0;
      drop_evt       = 1'b0;

      case (state_reg)
         REQ: begin
            imem_req = 1'b1;
            if (pc_src) begin
               // Redirect wins; a response that lands now belongs to the old path.
               pcf_next  = target;
               bubble_ld = accept;
               if (imem_rvalid) begin
                  drop_evt = 1'b1;
               end else begin
                  held_addr_next = pcf_reg;
                  state_next     = DROP;
               end
            end else if (imem_rvalid && accept && !stallF) begin
               ifid_load  = 1'b1;
               ifid_instr = imem_rdata;
               ifid_pc    = pcf_reg;
               ifid_valid = 1'b1;
               pcf_next   = pcf_plus4;
            end else if (imem_rvalid) begin
               buf_instr_next = imem_rdata;
               state_next     = BUF;
               bubble_ld      = accept;
            end else begin
               bubble_ld = accept;
            end
         end

         BUF: begin
            if (pc_src) begin
               pcf_next   = target;
               state_next = REQ;
               drop_evt   = 1'b1;
               bubble_ld  = accept;
            end else if (accept) begin
               ifid_load  = 1'b1;
               ifid_instr = buf_instr_reg;
               ifid_pc    = pcf_reg;
               ifid_valid = 1'b1;
               pcf_next   = pcf_plus4;
               state_next = REQ;
            end
         end

         DROP: begin
            // Keep the abandoned request stable until memory completes it.
            imem_req  = 1'b1;
            imem_addr = held_addr_reg;
            bubble_ld = accept;
            if (pc_src) begin
               pcf_next = target;
            end
            if (imem_rvalid) begin
               drop_evt   = 1'b1;
               state_next = REQ;
            end
         end

         default: begin
            state_next = REQ;
         end
      endcase

      if (bubble_ld) begin
         ifid_load = 1'b1;
      end
   end

   assign bubble_evt = bubble_ld && !flushD;

   if_id_reg #(
      .XLEN(XLEN)
   ) u_if_id_reg (
      .clk       (clk),
      .rst       (rst),
      .flushD    (flushD),
      .stallD    (stallD),
      .load      (ifid_load),
      .load_instr(ifid_instr),
      .load_pc   (ifid_pc),
      .load_valid(ifid_valid),
      .instrD    (instrD),
      .pcD       (pcD),
      .pc_plus4D (pc_plus4D),
      .validD    (validD)
   );

`ifdef FETCH_PERF_CNT_EN
   logic [1:0] cnt_evt;
   assign cnt_evt = {drop_evt, bubble_evt};

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
         logic [31:0] cnt_reg;
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               cnt_reg <= '0;
            end else if (cnt_evt[gi]) begin
               cnt_reg <= sat_inc(cnt_reg);
            end
         end
      end
   endgenerate

   assign bubble_cnt = g_cnt[0].cnt_reg;
   assign drop_cnt   = g_cnt[1].cnt_reg;
`else
   logic unused_evt;
   assign unused_evt = bubble_evt ^ drop_evt;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: directed scenarios, monitor compares each delivery.
module tb_fetch_stage;
   import riscv_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        stallF = 1'b0;
   logic        stallD = 1'b0;
   logic        flushD = 1'b0;
   logic        pc_src = 1'b0;
   logic [31:0] pc_targetE = 32'h0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic [31:0] instrD;
   logic [31:0] pcD;
   logic [31:0] pc_plus4D;
   logic        validD;
`ifdef FETCH_PERF_CNT_EN
   logic [31:0] bubble_cnt;
   logic [31:0] drop_cnt;
`endif

   fetch_stage #(
      .XLEN    (32),
      .RESET_PC(32'h0)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .stallF     (stallF),
      .stallD     (stallD),
      .flushD     (flushD),
      .pc_src     (pc_src),
      .pc_targetE (pc_targetE),
      .imem_req   (imem_req),
      .imem_addr  (imem_addr),
      .imem_rvalid(imem_rvalid),
      .imem_rdata (imem_rdata),
      .instrD     (instrD),
      .pcD        (pcD),
      .pc_plus4D  (pc_plus4D),
      .validD     (validD)
`ifdef FETCH_PERF_CNT_EN
      ,
      .bubble_cnt (bubble_cnt),
      .drop_cnt   (drop_cnt)
`endif
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      logic [31:0] instr;
      logic [31:0] pc;
   } exp_t;
   exp_t exp_q[$];

   // Memory model: response arrives in the lat-th cycle of a request.
   bit mem_en = 1'b0;
   int lat = 1;
   int wait_cnt = 0;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a == 32'h0) return 32'h0050_0093;
      return {a[23:0], 8'h13};
   endfunction

   always_comb begin
      imem_rvalid = mem_en && imem_req && (wait_cnt >= lat - 1);
      imem_rdata  = imem_rvalid ? mem_word(imem_addr) : 32'hDEAD_BEEF;
   end

   always @(posedge clk) begin
      if (rst || !imem_req || imem_rvalid) wait_cnt <= 0;
      else wait_cnt <= wait_cnt + 1;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic push(input logic [31:0] pc);
      exp_t e;
      e.instr = mem_word(pc);
      e.pc    = pc;
      exp_q.push_back(e);
   endtask

   // Monitor: a new IF/ID entry exists when validD is set and decode was not stalled.
   logic stall_q = 1'b1;
   always @(posedge clk) stall_q <= stallD || rst;

   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #2;
         if (validD && !stall_q) begin
            if (exp_q.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("[TB] FAIL unexpected_delivery: got pc=%h instr=%h, expected none", pcD, instrD);
            end else begin
               e = exp_q.pop_front();
               $display("[TB] deliver pc=%h instr=%h (expect pc=%h instr=%h)", pcD, instrD, e.pc, e.instr);
               check("mon_instr", instrD, e.instr);
               check("mon_pc", pcD, e.pc);
               check("mon_pc_plus4", pc_plus4D, e.pc + 32'd4);
            end
         end
      end
   end

   task automatic step(input int n);
      repeat (n) @(negedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      mem_en = 1'b0;
      lat = 1;
      stallF = 1'b0;
      stallD = 1'b0;
      flushD = 1'b0;
      pc_src = 1'b0;
      pc_targetE = 32'h0;
      step(2);
   endtask

   task automatic check_drained(input string name);
      check(name, 32'(exp_q.size()), 32'd0);
      exp_q.delete();
   endtask

   initial begin
      // Reset state and zero-wait streaming
      do_reset();
      check("rst_instrD", instrD, NOP_INSTR);
      check("rst_pcD", pcD, 32'h0);
      check("rst_pc_plus4D", pc_plus4D, 32'h0);
      check("rst_validD", 32'(validD), 32'd0);
      check("rst_imem_req", 32'(imem_req), 32'd1);
      check("rst_imem_addr", imem_addr, 32'h0);
      mem_en = 1'b1;
      for (int i = 0; i < 4; i++) push(32'(i * 4));
      rst = 1'b0;
      step(4);
      mem_en = 1'b0;
      step(1);
      check("t1_bubble_validD", 32'(validD), 32'd0);
      check_drained("t1_drained");

      // Slow memory: two bubbles before the first word
      do_reset();
      lat = 3;
      mem_en = 1'b1;
      push(32'h0);
      rst = 1'b0;
      for (int i = 0; i < 2; i++) begin
         step(1);
         check("t2_bubble_validD", 32'(validD), 32'd0);
         check("t2_bubble_instrD", instrD, NOP_INSTR);
         check("t2_addr_stable", imem_addr, 32'h0);
         check("t2_req_stable", 32'(imem_req), 32'd1);
      end
      step(1);
      mem_en = 1'b0;
`ifdef FETCH_PERF_CNT_EN
      check("t2_bubble_cnt", bubble_cnt, 32'd2);
`endif
      step(1);
      check_drained("t2_drained");

      // Response while stalled goes to the buffer
      do_reset();
      stallF = 1'b1;
      stallD = 1'b1;
      mem_en = 1'b1;
      rst = 1'b0;
      step(1);
      check("t3_buf_req", 32'(imem_req), 32'd0);
      check("t3_hold_validD", 32'(validD), 32'd0);
      step(1);
      check("t3_buf_req2", 32'(imem_req), 32'd0);
      check("t3_hold_instrD", instrD, NOP_INSTR);
      push(32'h0);
      stallF = 1'b0;
      stallD = 1'b0;
      step(1);
      mem_en = 1'b0;
      check("t3_next_addr", imem_addr, 32'h4);
      check("t3_next_req", 32'(imem_req), 32'd1);
      step(1);
      check_drained("t3_drained");

      // Redirect with outstanding request at 0x20
      do_reset();
      mem_en = 1'b1;
      for (int i = 0; i < 8; i++) push(32'(i * 4));
      rst = 1'b0;
      step(8);
      mem_en = 1'b0;
      check("t4_addr_20", imem_addr, 32'h20);
      pc_src = 1'b1;
      pc_targetE = 32'h100;
      flushD = 1'b1;
      step(1);
      pc_src = 1'b0;
      flushD = 1'b0;
      check("t4_drop_addr", imem_addr, 32'h20);
      check("t4_flush_validD", 32'(validD), 32'd0);
      step(1);
      check("t4_drop_addr2", imem_addr, 32'h20);
      check("t4_drop_req", 32'(imem_req), 32'd1);
      mem_en = 1'b1;
      step(1);
      check("t4_discard_validD", 32'(validD), 32'd0);
      check("t4_new_addr", imem_addr, 32'h100);
`ifdef FETCH_PERF_CNT_EN
      check("t4_drop_cnt", drop_cnt, 32'd1);
`endif
      push(32'h100);
      step(1);
      mem_en = 1'b0;
      step(1);
      check_drained("t4_drained");

      // Same-cycle redirect and response; target low bits ignored
      do_reset();
      mem_en = 1'b1;
      push(32'h0);
      rst = 1'b0;
      step(1);
      pc_src = 1'b1;
      pc_targetE = 32'h43;
      flushD = 1'b1;
      step(1);
      pc_src = 1'b0;
      flushD = 1'b0;
      check("t5_validD", 32'(validD), 32'd0);
      check("t5_instrD", instrD, NOP_INSTR);
      check("t5_addr", imem_addr, 32'h40);
`ifdef FETCH_PERF_CNT_EN
      check("t5_drop_cnt", drop_cnt, 32'd1);
`endif
      push(32'h40);
      step(1);
      mem_en = 1'b0;
      step(1);
      check_drained("t5_drained");

      // Asynchronous reset in the middle of DROP
      do_reset();
      mem_en = 1'b1;
      push(32'h0);
      rst = 1'b0;
      step(1);
      mem_en = 1'b0;
      pc_src = 1'b1;
      pc_targetE = 32'h80;
      flushD = 1'b1;
      step(1);
      pc_src = 1'b0;
      flushD = 1'b0;
      check("t6_held_addr", imem_addr, 32'h4);
      step(1);
      rst = 1'b1;
      #1;
      check("t6_rst_addr", imem_addr, 32'h0);
      check("t6_rst_req", 32'(imem_req), 32'd1);
      check("t6_rst_instrD", instrD, NOP_INSTR);
      check("t6_rst_validD", 32'(validD), 32'd0);
      check("t6_rst_pcD", pcD, 32'h0);
      check("t6_rst_pc_plus4D", pc_plus4D, 32'h0);
      step(1);
      mem_en = 1'b1;
      push(32'h0);
      rst = 1'b0;
      check("t6_first_addr", imem_addr, 32'h0);
      step(1);
      mem_en = 1'b0;
      step(1);
      check_drained("t6_drained");

      // PC wrap at the top of the address space
      do_reset();
      pc_src = 1'b1;
      pc_targetE = 32'hFFFF_FFFF;
      flushD = 1'b1;
      rst = 1'b0;
      step(1);
      pc_src = 1'b0;
      flushD = 1'b0;
      mem_en = 1'b1;
      step(1);
      check("t7_addr_top", imem_addr, 32'hFFFF_FFFC);
      push(32'hFFFF_FFFC);
      push(32'h0);
      step(2);
      mem_en = 1'b0;
      step(1);
      check_drained("t7_drained");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
IF stage plus IF/ID pipeline register of the 5-stage RV32I pipeline, sitting directly upstream of decode.
- Consumes stallF, stallD, flushD from the hazard unit, and pc_src / pc_targetE from EX.
- Owns the PC register and a single-outstanding request/response instruction-memory interface.
- Inserts NOP bubbles when memory is slow, and discards responses made stale by a taken branch.

Parameters:
XLEN, 32, datapath/address width
RESET_PC, 32'h0000_0000, PC value loaded on reset

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
stallF  in  1  hold PC / fetch (hazard unit)
stallD  in  1  hold IF/ID register (hazard unit)
flushD  in  1  clear IF/ID register (hazard unit)
pc_src  in  1  taken branch/jump resolved in EX
pc_targetE  in  XLEN  redirect target
imem_req  out  1  request valid
imem_addr  out  XLEN  request address, word aligned
imem_rvalid  in  1  response valid; may assert in the same cycle as imem_req
imem_rdata  in  32  instruction word
instrD  out  32  instruction to decode
pcD  out  XLEN  PC of instrD
pc_plus4D  out  XLEN  pcD+4
validD  out  1  instrD is real (0 = bubble)

Behaviour:
- Reset (async, any state, including mid-request): PCF=RESET_PC, state=REQ, buffer empty, instrD=32'h0000_0013 (NOP), pcD=0, pc_plus4D=0, validD=0. An outstanding memory request is abandoned; imem shares rst.
- Protocol:
  - One request outstanding at most.
  - imem_req/imem_addr stay stable until the cycle imem_rvalid=1, which completes the request.
  - imem_addr[1:0] is always 0.
- accept = !stallD.
- deliver(i,p): IF/ID loads instrD=i, pcD=p, pc_plus4D=p+4, validD=1; PCF<=PCF+4.
- State REQ: imem_req=1, imem_addr=PCF.
  - pc_src=1 (highest priority): PCF<=pc_targetE. If imem_rvalid=1 the same cycle, discard the response and stay REQ; else latch held_addr=PCF and go to DROP.
  - else imem_rvalid=1 and accept: deliver(imem_rdata,PCF), stay REQ.
  - else imem_rvalid=1 and !accept (or stallF): capture rdata/PCF into buffer, go to BUF.
  - else (no response): if accept, IF/ID loads a bubble (NOP, validD=0); PC holds.
- State BUF: imem_req=0.
  - pc_src=1: drop buffer, PCF<=pc_targetE, go to REQ.
  - else if accept: deliver(buffer), go to REQ.
  - else hold.
- State DROP: imem_req=1, imem_addr=held_addr.
  - pc_src=1: PCF<=pc_targetE (newest target wins), stay DROP.
  - imem_rvalid=1: discard response, go to REQ. If accept, IF/ID gets a bubble while in DROP.
- IF/ID priority: rst > flushD (NOP, validD=0) > stallD (hold) > load. flushD together with a valid response discards that response from the register; the state machine still follows the rules above. The hazard unit always asserts flushD with pc_src.
- PC arithmetic is modulo 2^XLEN: 32'hFFFF_FFFC+4 wraps to 0. pc_targetE[1:0] is forced to 0.
- Latency: zero-wait memory gives 1 instruction/cycle; response in cycle N appears on instrD at cycle N+1.

Optional Feature:
FETCH_PERF_CNT_EN
- Defined: adds output ports bubble_cnt[31:0] (count of bubbles inserted by the fetch stage only, not by flushD) and drop_cnt[31:0] (count of discarded responses, including same-cycle redirect discards). Both reset to 0 and saturate at 32'hFFFF_FFFF.
- Undefined: ports and logic are absent; functional behaviour is identical.

Decomposition:
- Package riscv_pkg:
  - XLEN_DEF
  - NOP_INSTR = 32'h0000_0013
  - RESET_PC_DEF
  - enum fetch_state_t {REQ, BUF, DROP} (2-bit)
- Sub-module if_id_reg: rst, flushD, stallD, load data in; instrD/pcD/pc_plus4D/validD out.
- fetch_stage holds the FSM, PCF, buffer and held_addr.

Test Plan:
- Zero-wait memory, no stalls, 4 cycles after reset -> pcD = 0,4,8,C consecutive; validD=1 from the 2nd cycle.
- 3-cycle memory latency, response 32'h00500093 at PC 0 -> two bubbles (validD=0, instrD=NOP); then instrD=32'h00500093, pcD=0.
- Response arrives while stallF=stallD=1 for 2 cycles -> state BUF, imem_req=0, IF/ID held. On release, instrD=buffered word; next imem_addr=PC+4.
- pc_src=1 with pc_targetE=32'h100 while a request is outstanding at 32'h20 -> imem_addr held at 32'h20 until rvalid. That response is discarded (validD=0). Next request is to 32'h100; with the macro defined, drop_cnt=1.
- pc_src=1 with pc_targetE=32'h40 and imem_rvalid=1 in the same cycle (with flushD) -> response discarded, IF/ID=NOP/validD=0, next imem_addr=32'h40.
- rst pulsed mid-DROP with PCF=32'h80 -> all outputs return to reset values immediately. After release, first imem_addr=RESET_PC.
